secded_stream_decoder: RTL and testbench
========================================

SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

Interface
REQ-001 Parameter DATA_W, default 4: data bits per codeword; legal range 4..26.
REQ-002 Parameter CNT_W, default 8: width of each error counter.
REQ-003 Derived P: smallest integer with 2^P >= DATA_W+P+1; CODE_W = DATA_W+P+1 (DATA_W=4 gives P=3, CODE_W=8).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  code_in holds a codeword.
REQ-007 in_ready  output  1  block accepts code_in this cycle.
REQ-008 code_in  input  CODE_W  received codeword.
REQ-009 correct_en  input  1  1 = correct single errors, 0 = detect only; sampled with the codeword.
REQ-010 out_valid  output  1  result fields valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 data_out  output  DATA_W  extracted, possibly corrected, data.
REQ-013 error_location  output  P  Hamming syndrome.
REQ-014 error_flag  output  2  00 none, 01 single, 10 double, 11 invalid syndrome.
REQ-015 cnt_clear  input  1  synchronous clear of both counters.
REQ-016 single_cnt, double_cnt  output  CNT_W each  error counters.
REQ-017 err_sticky  output  1  set on any non-00 result.

Function
REQ-018 code_in bit k (0..CODE_W-2) SHALL hold Hamming position k+1; positions 2^j SHALL be check bits; others data, d0 at lowest position, ascending.
REQ-019 Bit CODE_W-1 SHALL be overall parity: XOR of all CODE_W bits is 0 for a valid word.
REQ-020 Syndrome bit j SHALL be XOR of all bits at positions with bit j set; ov SHALL be XOR of all CODE_W bits.
REQ-021 Classification: syn=0,ov=0 -> 00; ov=1, syn<=CODE_W-1 -> 01; ov=1, syn>CODE_W-1 -> 11; syn!=0, ov=0 -> 10.
REQ-022 Flag 01 with correct_en=1: flip position syn (syn=0 flips bit CODE_W-1) before extraction; all other cases, and correct_en=0, extract uncorrected.
REQ-023 Two-stage pipeline: stage 1 registers code_in, syndrome, ov, correct_en; stage 2 registers outputs; latency 2 cycles from accepted input to out_valid.
REQ-024 Transfer on valid&ready each side; stage 2 loads when empty or out_ready=1; stage 1 loads when empty or stage 2 loads.
REQ-025 in_ready SHALL equal (stage1 empty) OR (stage 2 loading this cycle); combinational from out_ready permitted; no combinational path from in_valid to in_ready.
REQ-026 Full throughput: with out_ready held 1, one result per cycle, in order, none dropped or duplicated.
REQ-027 While out_valid=1 and out_ready=0, all output fields SHALL hold stable.
REQ-028 Counters increment once per accepted output transfer: single_cnt on 01, double_cnt on 10 or 11; saturate at 2^CNT_W-1.
REQ-029 cnt_clear has priority over increment in the same cycle; both counters read 0 next cycle; err_sticky cleared by cnt_clear too.
REQ-030 err_sticky SET has lower priority than cnt_clear; otherwise sets on output transfer with flag != 00.

Reset
REQ-031 rst_n low SHALL immediately clear both stage valids, out_valid=0, data_out=0, error_location=0, error_flag=00, counters=0, err_sticky=0.
REQ-032 Reset mid-stream discards in-flight words; in_ready=1 from first clock edge after rst_n rises.

Verification
REQ-033 DATA_W=4, code_in=8'h55, correct_en=1, out_ready=1 -> two cycles later data_out=4'b1011, flag 00, location 0.
REQ-034 code_in=8'h45 (bit 4 flipped) -> data_out=4'b1011, flag 01, location 5, single_cnt +1; same with correct_en=0 -> data_out=4'b1001.
REQ-035 code_in=8'hD5 -> data_out=4'b1011, flag 01, location 0; code_in=8'h56 -> flag 10, location 3, double_cnt +1.
REQ-036 DATA_W=8, valid word with bits 0,3,7 flipped -> location 13, flag 11, data uncorrected, double_cnt +1.
REQ-037 Back-to-back 8 words with out_ready toggling 1,0,0,1...: results in order, fields stable while stalled, in_ready low only when both stages full and out_ready=0.
REQ-038 CNT_W=2, 5 single-error words -> single_cnt saturates at 3; cnt_clear with concurrent error transfer -> 0; rst_n pulse mid-stream -> out_valid=0 immediately.

Source files
------------

// File: rtl/secded_stream_decoder.sv
// SECDED stream decoder: Hamming syndrome plus overall parity, two-stage
// valid/ready pipeline with saturating error counters and a sticky error flag.
module secded_stream_decoder #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    localparam int P      = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : 5,
    localparam int CODE_W = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    input  logic              correct_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [P-1:0]      error_location,
    output logic [1:0]        error_flag,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  single_cnt,
    output logic [CNT_W-1:0]  double_cnt,
    output logic              err_sticky
);

    localparam logic [P-1:0] MAX_POS = P'(CODE_W - 1);

    // Hamming position of data bit d: skip every power-of-two position.
    function automatic int data_pos(input int d);
        int pos;
        pos = d + 1;
        for (int j = 0; j < 6; j++)
            if ((1 << j) <= pos) pos = pos + 1;
        return pos;
    endfunction

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [P-1:0]      s1_syn;
    logic              s1_ov;
    logic              s1_cen;

    logic [P-1:0]      syn_c;
    logic [1:0]        flag_c;
    logic [CODE_W-1:0] fixed_c;
    logic [DATA_W-1:0] data_c;
    logic              s1_load;
    logic              s2_load;
    logic              out_fire;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign out_fire = out_valid && out_ready;

    // Syndrome bit j folds every Hamming position whose index has bit j set.
    always_comb begin
        syn_c = '0;
        for (int j = 0; j < P; j++)
            for (int k = 0; k < CODE_W - 1; k++)
                if ((((k + 1) >> j) & 1) != 0)
                    syn_c[j] = syn_c[j] ^ code_in[k];
    end

    // Stage 1: capture the word with its syndrome, parity and correct mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_ov    <= 1'b0;
            s1_cen   <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= code_in;
                s1_syn  <= syn_c;
                s1_ov   <= ^code_in;
                s1_cen  <= correct_en;
            end
        end
    end

    // Classify: odd parity means one flip unless the syndrome points nowhere.
    always_comb begin
        flag_c = 2'b00;
        if (s1_ov)
            flag_c = (s1_syn > MAX_POS) ? 2'b11 : 2'b01;
        else if (s1_syn != '0)
            flag_c = 2'b10;
    end

    // Flip the bit named by the syndrome; syndrome 0 names the parity bit.
    always_comb begin
        fixed_c = s1_code;
        if (flag_c == 2'b01 && s1_cen) begin
            if (s1_syn == '0)
                fixed_c[CODE_W-1] = ~s1_code[CODE_W-1];
            for (int k = 0; k < CODE_W - 1; k++)
                if (s1_syn == P'(k + 1))
                    fixed_c[k] = ~s1_code[k];
        end
    end

    for (genvar d = 0; d < DATA_W; d++) begin : g_data
        localparam int DP = data_pos(d);
        assign data_c[d] = fixed_c[DP-1];
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            data_out       <= '0;
            error_location <= '0;
            error_flag     <= 2'b00;
        end else if (s2_load) begin
            out_valid      <= 1'b1;
            data_out       <= data_c;
            error_location <= s1_syn;
            error_flag     <= flag_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Statistics on delivered results; clear beats any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_cnt <= '0;
            double_cnt <= '0;
            err_sticky <= 1'b0;
        end else if (cnt_clear) begin
            single_cnt <= '0;
            double_cnt <= '0;
            err_sticky <= 1'b0;
        end else if (out_fire) begin
            if (error_flag == 2'b01 && single_cnt != '1)
                single_cnt <= single_cnt + CNT_W'(1);
            if (error_flag[1] && double_cnt != '1)
                double_cnt <= double_cnt + CNT_W'(1);
            if (error_flag != 2'b00)
                err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Bench for secded_stream_decoder: a 4-bit/8-bit-count instance and an
// 8-bit/2-bit-count instance checked against a queue-based decode model.
module tb_secded_stream_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv4, ir4, cen4, ov4, or4, clr4, st4;
    logic [7:0] code4, sc4, dc4;
    logic [3:0] d4;
    logic [2:0] loc4;
    logic [1:0] fl4;

    logic        iv8, ir8, cen8, ov8, or8, clr8, st8;
    logic [12:0] code8;
    logic [7:0]  d8;
    logic [3:0]  loc8;
    logic [1:0]  fl8, sc8, dc8;

    secded_stream_decoder #(.DATA_W(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .code_in(code4), .correct_en(cen4), .out_valid(ov4),
        .out_ready(or4), .data_out(d4), .error_location(loc4),
        .error_flag(fl4), .cnt_clear(clr4), .single_cnt(sc4),
        .double_cnt(dc4), .err_sticky(st4)
    );

    secded_stream_decoder #(.DATA_W(8), .CNT_W(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .code_in(code8), .correct_en(cen8), .out_valid(ov8),
        .out_ready(or8), .data_out(d8), .error_location(loc8),
        .error_flag(fl8), .cnt_clear(clr8), .single_cnt(sc8),
        .double_cnt(dc8), .err_sticky(st8)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int calc_p(input int dw);
        for (int p = 1; p < 8; p++)
            if ((1 << p) >= dw + p + 1) return p;
        return 0;
    endfunction

    // Build a valid codeword from data the way a transmitter would.
    function automatic logic [31:0] encode(input int dw, input int data);
        int p, cw, n, syn;
        logic [31:0] c;
        p = calc_p(dw);
        cw = dw + p + 1;
        n = 0;
        syn = 0;
        c = '0;
        for (int pos = 1; pos < cw; pos++)
            if ($countones(pos) != 1) begin
                c[pos-1] = data[n];
                if (data[n]) syn = syn ^ pos;
                n++;
            end
        for (int j = 0; j < p; j++)
            c[(1 << j) - 1] = syn[j];
        c[cw-1] = ^c;
        return c;
    endfunction

    // Decode: syndrome is the XOR of the positions of all set bits.
    function automatic void model_decode(input int dw, input logic [31:0] code,
                                         input bit cen, output int data,
                                         output int loc, output int flag);
        int p, cw, syn, n;
        bit ov;
        logic [31:0] c;
        p = calc_p(dw);
        cw = dw + p + 1;
        c = code;
        syn = 0;
        for (int k = 0; k < cw - 1; k++)
            if (c[k]) syn = syn ^ (k + 1);
        ov = ^c;
        if (syn == 0 && !ov) flag = 0;
        else if (ov && syn <= cw - 1) flag = 1;
        else if (ov) flag = 3;
        else flag = 2;
        if (flag == 1 && cen) begin
            if (syn == 0) c[cw-1] = ~c[cw-1];
            else c[syn-1] = ~c[syn-1];
        end
        data = 0;
        n = 0;
        for (int pos = 1; pos < cw; pos++)
            if ($countones(pos) != 1) begin
                if (c[pos-1]) data = data + (1 << n);
                n++;
            end
        loc = syn;
    endfunction

    function automatic int sat_inc(input int v, input int w);
        return (v < (1 << w) - 1) ? v + 1 : v;
    endfunction

    typedef struct {
        int data;
        int loc;
        int flag;
        int acc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];
    int msc4 = 0, mdc4 = 0, mst4 = 0;
    int msc8 = 0, mdc8 = 0, mst8 = 0;

    always @(negedge clk) begin : mon4
        int d, l, f;
        bit eov;
        exp_t e;
        if (!rst_n) begin
            q4.delete();
            msc4 = 0; mdc4 = 0; mst4 = 0;
            chk("rst_ov4", ov4, 0);
            chk("rst_d4", d4, 0);
            chk("rst_loc4", loc4, 0);
            chk("rst_fl4", fl4, 0);
            chk("rst_cnt4", sc4 + dc4 + st4, 0);
        end else begin
            eov = q4.size() > 0 && (cyc - q4[0].acc >= 1);
            chk("m_ov4", ov4, eov);
            if (ov4 && eov) begin
                chk("m_data4", d4, q4[0].data);
                chk("m_loc4", loc4, q4[0].loc);
                chk("m_flag4", fl4, q4[0].flag);
            end
            chk("m_ir4", ir4, !(q4.size() == 2 && !or4));
            chk("m_sc4", sc4, msc4);
            chk("m_dc4", dc4, mdc4);
            chk("m_st4", st4, mst4);
            if (ov4 && or4 && q4.size() > 0) begin
                f = q4[0].flag;
                void'(q4.pop_front());
                if (f == 1) msc4 = sat_inc(msc4, 8);
                if (f >= 2) mdc4 = sat_inc(mdc4, 8);
                if (f != 0) mst4 = 1;
            end
            if (clr4) begin
                msc4 = 0; mdc4 = 0; mst4 = 0;
            end
            if (iv4 && ir4) begin
                model_decode(4, {24'd0, code4}, cen4, d, l, f);
                e.data = d; e.loc = l; e.flag = f; e.acc = cyc + 1;
                q4.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : mon8
        int d, l, f;
        bit eov;
        exp_t e;
        if (!rst_n) begin
            q8.delete();
            msc8 = 0; mdc8 = 0; mst8 = 0;
            chk("rst_ov8", ov8, 0);
            chk("rst_cnt8", sc8 + dc8 + st8, 0);
        end else begin
            eov = q8.size() > 0 && (cyc - q8[0].acc >= 1);
            chk("m_ov8", ov8, eov);
            if (ov8 && eov) begin
                chk("m_data8", d8, q8[0].data);
                chk("m_loc8", loc8, q8[0].loc);
                chk("m_flag8", fl8, q8[0].flag);
            end
            chk("m_ir8", ir8, !(q8.size() == 2 && !or8));
            chk("m_sc8", sc8, msc8);
            chk("m_dc8", dc8, mdc8);
            chk("m_st8", st8, mst8);
            if (ov8 && or8 && q8.size() > 0) begin
                f = q8[0].flag;
                void'(q8.pop_front());
                if (f == 1) msc8 = sat_inc(msc8, 2);
                if (f >= 2) mdc8 = sat_inc(mdc8, 2);
                if (f != 0) mst8 = 1;
            end
            if (clr8) begin
                msc8 = 0; mdc8 = 0; mst8 = 0;
            end
            if (iv8 && ir8) begin
                model_decode(8, {19'd0, code8}, cen8, d, l, f);
                e.data = d; e.loc = l; e.flag = f; e.acc = cyc + 1;
                q8.push_back(e);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push4(input logic [7:0] c, input bit cen);
        bit ok;
        ok = 1'b0;
        iv4 = 1'b1; code4 = c; cen4 = cen;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ir4;
        end
        if (!ok) chk("push4_timeout", 0, 1);
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic push8(input logic [12:0] c, input bit cen);
        bit ok;
        ok = 1'b0;
        iv8 = 1'b1; code8 = c; cen8 = cen;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ir8;
        end
        if (!ok) chk("push8_timeout", 0, 1);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic one4(input logic [7:0] c, input bit cen, input int ed,
                        input int el, input int ef, input int es, input int edd);
        push4(c, cen);
        @(negedge clk);
        chk("lat_ov4", ov4, 0);
        @(negedge clk);
        chk("lit_ov4", ov4, 1);
        chk("lit_data4", d4, ed);
        chk("lit_loc4", loc4, el);
        chk("lit_flag4", fl4, ef);
        @(negedge clk);
        chk("lit_sc4", sc4, es);
        chk("lit_dc4", dc4, edd);
        @(posedge clk); #1;
    endtask

    task automatic one8(input logic [12:0] c, input bit cen, input int ed,
                        input int el, input int ef, input int es, input int edd);
        push8(c, cen);
        @(negedge clk);
        chk("lat_ov8", ov8, 0);
        @(negedge clk);
        chk("lit_ov8", ov8, 1);
        chk("lit_data8", d8, ed);
        chk("lit_loc8", loc8, el);
        chk("lit_flag8", fl8, ef);
        @(negedge clk);
        chk("lit_sc8", sc8, es);
        chk("lit_dc8", dc8, edd);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, l, f;
        logic [31:0] w;
        iv4 = 0; code4 = '0; cen4 = 1; or4 = 1; clr4 = 0;
        iv8 = 0; code8 = '0; cen8 = 1; or8 = 1; clr8 = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("pin_enc4", encode(4, 11), 'h55);
        model_decode(4, 32'h45, 1'b0, d, l, f);
        chk("pin_dec4_d", d, 9);
        chk("pin_dec4_l", l, 5);
        chk("pin_dec4_f", f, 1);
        w = encode(8, 'hA5) ^ 32'h89;
        model_decode(8, w, 1'b1, d, l, f);
        chk("pin_dec8_d", d, 'hA5);
        chk("pin_dec8_l", l, 13);
        chk("pin_dec8_f", f, 3);

        one4(8'h55, 1'b1, 11, 0, 0, 0, 0);
        one4(8'h45, 1'b1, 11, 5, 1, 1, 0);
        one4(8'h45, 1'b0, 9, 5, 1, 2, 0);
        one4(8'hD5, 1'b1, 11, 0, 1, 3, 0);
        one4(8'h56, 1'b1, 11, 3, 2, 3, 1);
        chk("lit_st4", st4, 1);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    or4 = (i % 4 == 0) || (i % 4 == 3);
                    @(posedge clk); #1;
                end
                or4 = 1'b1;
            end
            begin
                logic [31:0] v;
                for (int i = 0; i < 8; i++) begin
                    v = encode(4, i + 3);
                    if (i % 3 == 0) v = v ^ (32'd1 << (i % 8));
                    push4(v[7:0], i[0]);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("drain4", q4.size(), 0);

        w = encode(8, 'hA5) ^ 32'h89;
        one8(w[12:0], 1'b1, 'hA5, 13, 3, 0, 1);
        for (int i = 0; i < 5; i++) begin
            w = encode(8, 17 * i) ^ (32'd1 << (i + 2));
            push8(w[12:0], 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("sat_sc8", sc8, 3);
        chk("sat_dc8", dc8, 1);

        w = encode(8, 'h3C) ^ (32'd1 << 12);
        push8(w[12:0], 1'b1);
        @(posedge clk); #1;
        clr8 = 1'b1;
        chk("clr_ov8", ov8, 1);
        chk("clr_fl8", fl8, 1);
        @(posedge clk); #1;
        clr8 = 1'b0;
        chk("clr_sc8", sc8, 0);
        chk("clr_dc8", dc8, 0);
        chk("clr_st8", st8, 0);

        or4 = 1'b0;
        push4(8'h55, 1'b1);
        push4(8'h45, 1'b1);
        chk("full_ir4", ir4, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov4", ov4, 0);
        chk("mid_rst_sc4", sc4, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        or4 = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ir4", ir4, 1);

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    or4 = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                or4 = 1'b1;
            end
            begin
                logic [31:0] v;
                for (int i = 0; i < 12; i++) begin
                    v = encode(4, $urandom_range(0, 15));
                    if ($urandom_range(0, 2) != 0)
                        v = v ^ (32'd1 << $urandom_range(0, 7));
                    if ($urandom_range(0, 3) == 0)
                        v = v ^ (32'd1 << $urandom_range(0, 7));
                    push4(v[7:0], 1'($urandom_range(0, 1)));
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("drain4b", q4.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
